operand_loader: RTL
===================

Name: operand_loader

Overview:
Parametrised successor to the two-operand input-control FSM. It collects N_OPERANDS words of WIDTH bits from a shared switch bus, one word per press of an active-low load button, then presents all words with a valid/ready handshake to the downstream compute block. It adds a synchroniser with edge detection, an operand index, an abort input and a back-to-back restart.

Parameters:
WIDTH, 4, bits per operand (>=1)
N_OPERANDS, 2, operands per transaction (>=1)
SYNC_STAGES, 2, synchroniser flops on load_i and input_i (>=2)

Ports:
clk_i  input  1  single clock, rising edge
rst_i  input  1  asynchronous, active-low reset
load_i  input  1  load button, active low, asynchronous to clk_i
input_i  input  WIDTH  operand switches, asynchronous, quasi-static
clear_i  input  1  synchronous active-high abort
ready_i  input  1  downstream accepts the operand set
operands_o  output  N_OPERANDS*WIDTH  operand k at bits [k*WIDTH +: WIDTH]
valid_o  output  1  operand set complete
idx_o  output  max(1,$clog2(N_OPERANDS))  index of the next operand to capture
fsm_state_o  output  2  debug copy of the state encoding

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: operands_o=0, valid_o=0, idx_o=0, fsm_state_o=IDLE(0). All sync flops reset to 1 (released) for load and 0 for data.
- load_i and input_i each pass through a SYNC_STAGES flop chain. A press is detected when the previous synced load is 1 and the current synced load is 0 (falling edge).
- Capture latency: the operand register updates on the (SYNC_STAGES+1)th rising edge, counting the first edge that samples load_i low. It stores input_i as sampled on that first edge.
- IDLE(0): wait for the synced load to read 1 for at least one cycle, then go to COLLECT. A button held through reset must never produce a capture.
- COLLECT(1), on a press:
  - operand[idx] <= synced input and idx++.
  - If idx was N_OPERANDS-1: idx <= 0, valid_o <= 1, go to DONE on the same edge as the last capture.
  - N_OPERANDS=1 means the first press goes directly to DONE.
- DONE(2):
  - valid_o held high and operands_o stable.
  - Presses are ignored, not queued.
  - When valid_o & ready_i: valid_o <= 0 and return to COLLECT (idx=0) on the next edge.
  - Operands keep their values until overwritten.
- Encoding 3 is illegal; it must recover to IDLE on the next edge with valid_o=0.
- clear_i=1 (any state):
  - valid_o <= 0, idx <= 0.
  - IDLE stays IDLE; COLLECT and DONE go to COLLECT.
  - operands_o retained.
- Priority: clear_i > ready_i handshake > press. A press in the same cycle as clear_i or as the accepting handshake is dropped.
- Releases never capture. Holding the button gives exactly one capture per press.
- Reset mid-transaction: immediate return to reset values; the partial operand set is discarded.

Decomposition:
- Shared package loader_pkg:
  - typedef enum logic [1:0] loader_state_t {LDR_IDLE=2'd0, LDR_COLLECT=2'd1, LDR_DONE=2'd2}.
  - Localparam helper for the index width.
- One sub-module, press_sync, parameters WIDTH and SYNC_STAGES. It contains the load and data synchronisers, the previous-load register and the press-pulse output.
- operand_loader holds the FSM, index counter and operand array.

Test Plan:
- Defaults. Reset with load_i=1, then press with input_i=4'h3 and release, then press with input_i=4'hA. Expect operands_o=8'hA3 and valid_o=1 exactly 3 edges after the second press is first sampled. idx_o sequence is 0→1→0. A third press while in DONE leaves operands unchanged.
- Hold load_i=0 through reset release with input_i=4'h7. Expect no capture, state IDLE, idx_o=0. Release, then one press. Expect operand0=4'h7 and idx_o=1.
- With valid_o=1, hold ready_i=0 for 10 cycles, then drive 1 for one cycle. valid_o must stay high and stable for those 10 cycles, then drop on the next edge with state COLLECT. A following pair of presses with 4'h1 and 4'h2 gives 8'h21.
- After one capture (idx_o=1), assert clear_i for one cycle. Expect idx_o=0, valid_o=0, operand0 retained. A press coinciding with clear_i is dropped.
- WIDTH=8, N_OPERANDS=3, SYNC_STAGES=3. Presses with 8'h11, 8'h22, 8'h33 give operands_o=24'h332211. Capture latency is 4 edges per press.
- Force the state register to 2'b11. Expect state IDLE next edge and valid_o=0. Assert rst_i=0 mid-COLLECT. Expect all outputs at reset values asynchronously.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and helpers for the operand loader.
package loader_pkg;

  typedef enum logic [1:0] {
    LDR_IDLE    = 2'd0,
    LDR_COLLECT = 2'd1,
    LDR_DONE    = 2'd2
  } loader_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_loader_press_sync.sv
// Synchronises the load button and operand switches, and flags each falling
// edge of the synced button as a single-cycle press.
module press_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] input_i,
  output logic             load_sync_o,
  output logic [WIDTH-1:0] data_sync_o,
  output logic             press_o
);

  logic [SYNC_STAGES-1:0]            load_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] data_q;
  logic                              load_prev_q;

  // Load chain resets to "released" so reset alone never looks like a press.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      load_q      <= '1;
      data_q      <= '0;
      load_prev_q <= 1'b1;
    end else begin
      load_q      <= {load_q[SYNC_STAGES-2:0], load_i};
      data_q      <= {data_q[SYNC_STAGES-2:0], input_i};
      load_prev_q <= load_q[SYNC_STAGES-1];
    end
  end

  assign load_sync_o = load_q[SYNC_STAGES-1];
  assign data_sync_o = data_q[SYNC_STAGES-1];
  assign press_o     = load_prev_q & ~load_q[SYNC_STAGES-1];

endmodule

// File: rtl/operand_loader.sv
// Collects N_OPERANDS button-loaded words and hands them downstream with a
// valid/ready handshake.
//   state   | meaning
//   IDLE    | wait until the synced button has read released long enough
//   COLLECT | capture one operand per press, idx_o points at the next slot
//   DONE    | operand set valid, presses ignored until accepted
module operand_loader
  import loader_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int N_OPERANDS  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  load_i,
  input  logic [WIDTH-1:0]                      input_i,
  input  logic                                  clear_i,
  input  logic                                  ready_i,
  output logic [N_OPERANDS*WIDTH-1:0]           operands_o,
  output logic                                  valid_o,
  output logic [idx_width(N_OPERANDS)-1:0]      idx_o,
  output logic [1:0]                            fsm_state_o
);

  localparam int IDX_W = idx_width(N_OPERANDS);
  localparam int CNT_W = $clog2(SYNC_STAGES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPERANDS - 1);
  localparam logic [CNT_W-1:0] SETTLE   = CNT_W'(SYNC_STAGES);

  logic             load_sync;
  logic             press;
  logic [WIDTH-1:0] data_sync;

  loader_state_t                     state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic                              valid_q, valid_d;
  logic [CNT_W-1:0]                  settle_q, settle_d;
  logic                              cap_en;
  logic [N_OPERANDS-1:0][WIDTH-1:0]  ops_q;

  press_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_press_sync (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load_i),
    .input_i     (input_i),
    .load_sync_o (load_sync),
    .data_sync_o (data_sync),
    .press_o     (press)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= LDR_IDLE;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      settle_q <= SETTLE;
      ops_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      settle_q <= settle_d;
      if (cap_en) ops_q[idx_q] <= data_sync;
    end
  end

  // Settle timer spans the sync chain so a button held through reset is
  // seen low before IDLE can ever leave.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    settle_d = settle_q;
    cap_en   = 1'b0;
    case (state_q)
      LDR_IDLE: begin
        valid_d = 1'b0;
        idx_d   = '0;
        if (!load_sync)          settle_d = SETTLE;
        else if (settle_q != '0) settle_d = settle_q - CNT_W'(1);
        else if (!clear_i)       state_d  = LDR_COLLECT;
      end
      LDR_COLLECT: begin
        if (clear_i) begin
          valid_d = 1'b0;
          idx_d   = '0;
        end else if (press) begin
          cap_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            valid_d = 1'b1;
            state_d = LDR_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      LDR_DONE: begin
        if (clear_i || (valid_q && ready_i)) begin
          valid_d = 1'b0;
          idx_d   = '0;
          state_d = LDR_COLLECT;
        end
      end
      default: begin
        state_d  = LDR_IDLE;
        valid_d  = 1'b0;
        idx_d    = '0;
        settle_d = SETTLE;
      end
    endcase
  end

  assign operands_o  = ops_q;
  assign valid_o     = valid_q;
  assign idx_o       = idx_q;
  assign fsm_state_o = state_q;

endmodule
